// File: rtl/not_sched_pkg.sv
// Shared constants and the FSM state type for the not_rr_sched scheduler.
package not_sched_pkg;

  localparam int CNT_W  = 8;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/not_rr_sched_if.sv
// Request/grant and valid/ready response bundle between requesters and not_rr_sched.
interface not_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 1,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_data;
  logic [IDW-1:0]           resp_id;
  logic                     busy;

  modport master (
    output req, req_data, resp_ready,
    input  gnt, resp_valid, resp_data, resp_id, busy
  );

  modport slave (
    input  req, req_data, resp_ready,
    output gnt, resp_valid, resp_data, resp_id, busy
  );
endinterface

// File: rtl/not_stage.sv
// Shared registered inverter: y holds ~a from the last cycle en was high.
module not_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] r_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   r_y <= '0;
    else if (en) r_y <= ~a;
  end

  assign y = r_y;
endmodule

// File: rtl/not_rr_sched.sv
// Round-robin scheduler sharing one not_stage among NUM_REQ requesters.
// Optional per-requester grant counters are enabled with NOT_SCHED_STATS_EN.
module not_rr_sched
  import not_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 1,
  parameter int LAT     = 1,
  parameter int IDW     = 2
) (
  input  logic clock,
  input  logic reset,
  not_rr_sched_if.slave bus
`ifdef NOT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);
  state_t           r_state, w_nextState;
  logic [IDW-1:0]   r_ptr, w_pick, r_respId;
  logic [CNT_W-1:0] r_cnt;
  logic             r_respValid, r_busy, w_grant;
  logic [WIDTH-1:0] r_respData, w_selData, w_stageY;

  // First requester at or above ptr, wrapping past NUM_REQ-1 back to 0.
  function automatic logic [IDW-1:0] pickNext(input logic [NUM_REQ-1:0] req,
                                              input logic [IDW-1:0] ptr);
    logic [IDW-1:0] sel;
    logic [IDW:0]   sum;
    logic           found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!found && req[sum[IDW-1:0]]) begin
        sel   = sum[IDW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_pick    = pickNext(bus.req, r_ptr);
  assign w_grant   = (r_state == ST_IDLE) && (|bus.req);
  assign w_selData = bus.req_data[int'(w_pick)*WIDTH +: WIDTH];

  // The stage register doubles as the operand register, captured on the grant edge.
  not_stage #(.WIDTH(WIDTH)) u_stage (
    .clock (clock),
    .reset (reset),
    .en    (w_grant),
    .a     (w_selData),
    .y     (w_stageY)
  );

  always_comb begin
    bus.gnt = '0;
    if (w_grant) bus.gnt[w_pick] = 1'b1;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (|bus.req)        w_nextState = ST_EXEC;
      ST_EXEC: if (r_cnt == '0)     w_nextState = ST_RESP;
      ST_RESP: if (bus.resp_ready)  w_nextState = ST_IDLE;
      default:                      w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_respId    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_grant) begin
          r_respId <= w_pick;
          r_ptr    <= (w_pick == IDW'(NUM_REQ-1)) ? '0 : w_pick + 1'b1;
          r_cnt    <= CNT_W'(LAT-1);
          r_busy   <= 1'b1;
        end
        ST_EXEC: if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_respData  <= w_stageY;
          r_respValid <= 1'b1;
        end
        ST_RESP: if (bus.resp_ready) begin
          r_respValid <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = r_respValid;
  assign bus.resp_data  = r_respData;
  assign bus.resp_id    = r_respId;
  assign bus.busy       = r_busy;

`ifdef NOT_SCHED_STATS_EN
  logic [STAT_W-1:0] r_grantCnt [NUM_REQ];

  // Saturating counters so a long run never wraps back to a small count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_grantCnt[i] <= '0;
    end else if (w_grant && (r_grantCnt[w_pick] != '1)) begin
      r_grantCnt[w_pick] <= r_grantCnt[w_pick] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*STAT_W +: STAT_W] = r_grantCnt[i];
  end
`endif
endmodule

// File: tb/tb_not_rr_sched.sv
// Directed self-checking bench for not_rr_sched (LAT=1 and LAT=4 instances).
// Define NOT_SCHED_STATS_EN to also exercise the grant counters.
module tb_not_rr_sched;
  logic clock, reset;
  int compared   = 0;
  int mismatched = 0;

  not_rr_sched_if #(.NUM_REQ(4), .WIDTH(1), .IDW(2)) bus ();
  not_rr_sched_if #(.NUM_REQ(4), .WIDTH(1), .IDW(2)) bus4 ();

`ifdef NOT_SCHED_STATS_EN
  logic [63:0] grantCnt, grantCnt4;
`endif

  not_rr_sched #(.NUM_REQ(4), .WIDTH(1), .LAT(1), .IDW(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef NOT_SCHED_STATS_EN
    ,
    .grant_cnt (grantCnt)
`endif
  );

  not_rr_sched #(.NUM_REQ(4), .WIDTH(1), .LAT(4), .IDW(2)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
`ifdef NOT_SCHED_STATS_EN
    ,
    .grant_cnt (grantCnt4)
`endif
  );

  // Rising edges at 10, 20, ...; the bench acts on falling edges.
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #5 reset = 1'b1;
    #10 reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); #1;
      compared++;
      if ({bus.gnt, bus.resp_valid, bus.busy, bus.resp_data} !== 7'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_idle cycle %0d: got gnt/valid/busy/data %b, expected 0000000", c,
                 {bus.gnt, bus.resp_valid, bus.busy, bus.resp_data});
      end
    end
    compared++;
    if (bus.resp_id !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_id: got %0d expected 0", bus.resp_id);
    end
  endtask

  task automatic test_single();
    applyReset();
    @(negedge clock);
    bus.req = 4'b0100; bus.req_data = 4'b0100; #1;
    compared++;
    if (bus.gnt !== 4'b0100) begin
      mismatched++; $display("[TB] FAIL single_gnt: got %b expected 0100", bus.gnt);
    end
    @(negedge clock);
    bus.req = 4'b0000; #1;
    compared++;
    if ({bus.gnt, bus.busy, bus.resp_valid} !== 6'b0000_1_0) begin
      mismatched++; $display("[TB] FAIL single_exec: got gnt/busy/valid %b expected 000010",
                             {bus.gnt, bus.busy, bus.resp_valid});
    end
    @(negedge clock); #1;
    compared++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== 4'b1_10_0) begin
      mismatched++; $display("[TB] FAIL single_resp: got valid/id/data %b expected 1100",
                             {bus.resp_valid, bus.resp_id, bus.resp_data});
    end
    bus.resp_ready = 1'b1;
    @(negedge clock); #1;
    bus.resp_ready = 1'b0;
    compared++;
    if ({bus.resp_valid, bus.busy} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL single_done: got valid/busy %b expected 00",
                             {bus.resp_valid, bus.busy});
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] dat;
    logic [3:0] expGnt;
    logic       expData;
    dat = 4'b1010;
    applyReset();
    for (int g = 0; g < 5; g++) begin
      expGnt  = 4'b0001 << order[g];
      expData = ~dat[order[g]];
      @(negedge clock);
      if (g == 0) begin
        bus.req = 4'b1111; bus.req_data = dat; bus.resp_ready = 1'b1;
      end
      #1;
      compared++;
      if (bus.gnt !== expGnt) begin
        mismatched++; $display("[TB] FAIL rr_gnt #%0d: got %b expected %b", g, bus.gnt, expGnt);
      end
      @(negedge clock); #1;
      compared++;
      if (bus.gnt !== 4'b0000) begin
        mismatched++; $display("[TB] FAIL rr_exec_gnt #%0d: got %b expected 0000", g, bus.gnt);
      end
      @(negedge clock);
      if (g == 4) bus.req = 4'b0000;
      #1;
      compared++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 2'(order[g]), expData}) begin
        mismatched++; $display("[TB] FAIL rr_resp #%0d: got valid/id/data %b expected %b", g,
                               {bus.resp_valid, bus.resp_id, bus.resp_data},
                               {1'b1, 2'(order[g]), expData});
      end
    end
    @(negedge clock);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    applyReset();
    @(negedge clock);
    bus.req = 4'b0011; bus.req_data = 4'b0001; bus.resp_ready = 1'b0; #1;
    compared++;
    if (bus.gnt !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL bp_gnt0: got %b expected 0001", bus.gnt);
    end
    @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      compared++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.gnt} !== 8'b1_00_0_0000) begin
        mismatched++; $display("[TB] FAIL bp_hold cycle %0d: got valid/id/data/gnt %b expected 10000000",
                               c, {bus.resp_valid, bus.resp_id, bus.resp_data, bus.gnt});
      end
    end
    @(negedge clock);
    bus.resp_ready = 1'b1;
    @(negedge clock); #1;
    bus.resp_ready = 1'b0;
    compared++;
    if ({bus.gnt, bus.busy} !== 5'b0010_0) begin
      mismatched++; $display("[TB] FAIL bp_next_gnt: got gnt/busy %b expected 00100", {bus.gnt, bus.busy});
    end
    @(negedge clock);
    bus.req = 4'b0000;
    @(negedge clock); #1;
    compared++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== 4'b1_01_1) begin
      mismatched++; $display("[TB] FAIL bp_resp1: got valid/id/data %b expected 1011",
                             {bus.resp_valid, bus.resp_id, bus.resp_data});
    end
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    applyReset();
    @(negedge clock);
    bus4.req = 4'b0001; bus4.req_data = 4'b0001; #1;
    compared++;
    if (bus4.gnt !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL mid_gnt: got %b expected 0001", bus4.gnt);
    end
    @(negedge clock);
    bus4.req = 4'b0000;
    @(negedge clock);
    reset = 1'b1; #2; reset = 1'b0; #1;
    compared++;
    if ({bus4.busy, bus4.resp_valid} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL mid_cleared: got busy/valid %b expected 00", {bus4.busy, bus4.resp_valid});
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock); #1;
      compared++;
      if (bus4.resp_valid !== 1'b0) begin
        mismatched++; $display("[TB] FAIL mid_no_resp cycle %0d: got %b expected 0", c, bus4.resp_valid);
      end
    end
    @(negedge clock);
    bus4.req = 4'b1001; bus4.req_data = 4'b0001; #1;
    compared++;
    if (bus4.gnt !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL mid_ptr0_gnt: got %b expected 0001", bus4.gnt);
    end
    @(negedge clock);
    bus4.req = 4'b0000;
    repeat (3) @(negedge clock);
    #1;
    compared++;
    if (bus4.resp_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL lat4_early: got valid %b expected 0", bus4.resp_valid);
    end
    @(negedge clock); #1;
    compared++;
    if ({bus4.resp_valid, bus4.resp_id, bus4.resp_data} !== 4'b1_00_0) begin
      mismatched++; $display("[TB] FAIL lat4_resp: got valid/id/data %b expected 1000",
                             {bus4.resp_valid, bus4.resp_id, bus4.resp_data});
    end
    bus4.resp_ready = 1'b1;
    @(negedge clock); #1;
    bus4.resp_ready = 1'b0;
    compared++;
    if (bus4.resp_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL lat4_done: got valid %b expected 0", bus4.resp_valid);
    end
  endtask

`ifdef NOT_SCHED_STATS_EN
  task automatic test_stats();
    applyReset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      bus.req = 4'b0010; bus.req_data = 4'b0000;
      @(negedge clock);
      bus.req = 4'b0000;
      @(negedge clock);
      bus.resp_ready = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
    end
    #1;
    compared++;
    if (grantCnt !== {16'd0, 16'd0, 16'd3, 16'd0}) begin
      mismatched++; $display("[TB] FAIL stats_count: got %h expected 0000000000030000", grantCnt);
    end
    applyReset();
    @(negedge clock); #1;
    compared++;
    if (grantCnt !== 64'd0) begin
      mismatched++; $display("[TB] FAIL stats_reset: got %h expected 0", grantCnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    bus.req = '0;  bus.req_data = '0;  bus.resp_ready = 1'b0;
    bus4.req = '0; bus4.req_data = '0; bus4.resp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef NOT_SCHED_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
